// File: rtl/shiftreg_ctrl.sv
// rtl/shiftreg_ctrl.sv - FIFO-style controller for a long shift-register datapath
module shiftreg_ctrl #(
    parameter int DEPTH = 20000,
    parameter int CW    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    input  logic          flush,
    output logic          sr_shift,
    output logic [7:0]    sr_din,
    input  logic [7:0]    sr_dout,
    output logic [CW-1:0] fill_count,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FILL  = 2'd1,
        S_FULL  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

    state_t        state_q;
    logic [CW-1:0] vcnt_q;
    logic [CW-1:0] lead_q;
    logic          accept;

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        sr_shift  = 1'b0;
        sr_din    = 8'h00;
        accept    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_EMPTY, S_FILL: begin
                    in_ready = 1'b1;
                    sr_din   = in_data;
                    sr_shift = in_valid;
                    accept   = in_valid;
                end
                S_FULL: begin
                    // Input and output move together; the incoming word pushes the oldest out.
                    in_ready  = out_ready;
                    out_valid = in_valid;
                    out_data  = in_valid ? sr_dout : 8'h00;
                    sr_din    = in_data;
                    sr_shift  = in_valid && out_ready;
                end
                default: begin
                    if (lead_q != LAST_C) begin
                        sr_shift = 1'b1;
                    end else begin
                        out_valid = 1'b1;
                        out_data  = sr_dout;
                        sr_shift  = out_ready;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            vcnt_q  <= '0;
            lead_q  <= '0;
        end else begin
            case (state_q)
                S_EMPTY, S_FILL: begin
                    if (accept) begin
                        vcnt_q <= vcnt_q + CW'(1);
                        lead_q <= vcnt_q;
                    end
                    if (flush && state_q == S_FILL) begin
                        state_q <= S_DRAIN;
                    end else if (accept && (vcnt_q + CW'(1) == DEPTH_C)) begin
                        state_q <= S_FULL;
                    end else if (accept) begin
                        state_q <= S_FILL;
                    end
                end
                S_FULL: begin
                    if (flush) begin
                        state_q <= S_DRAIN;
                    end
                end
                default: begin
                    // Bubble-shift the oldest word to the last stage before presenting it.
                    if (lead_q != LAST_C) begin
                        lead_q <= lead_q + CW'(1);
                    end else if (out_ready) begin
                        vcnt_q <= vcnt_q - CW'(1);
                        if (vcnt_q == CW'(1)) begin
                            state_q <= S_EMPTY;
                            lead_q  <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign fill_count = vcnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_shiftreg_ctrl.sv
// tb/tb_shiftreg_ctrl.sv - self-checking bench for shiftreg_ctrl with a 4-stage datapath
module tb_shiftreg_ctrl;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'h00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic          flush = 1'b0;
    logic          sr_shift;
    logic [7:0]    sr_din;
    logic [7:0]    sr_dout;
    logic [CW-1:0] fill_count;
    logic [1:0]    state;

    shiftreg_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .sr_shift(sr_shift), .sr_din(sr_din), .sr_dout(sr_dout),
        .fill_count(fill_count), .state(state)
    );

    always #5 clk = ~clk;

    logic [7:0] stage [DEPTH];
    always @(posedge clk) begin
        if (sr_shift) begin
            stage[0] <= sr_din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end
    assign sr_dout = stage[DEPTH-1];

    int checks = 0;
    int errors = 0;
    logic [7:0] mq [$];
    int mst = 0;
    int bub = 0;
    logic [7:0] got [$];
    int shifts = 0;
    int bubble_cycles = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        logic       e_ir, e_ov, e_sh;
        logic [7:0] e_od, e_din;
        @(negedge clk);
        e_ir = 0; e_ov = 0; e_sh = 0; e_od = 0; e_din = 0;
        if (!rst) begin
            case (mst)
                0, 1: begin e_ir = 1; e_sh = in_valid; e_din = in_data; end
                2: begin
                    e_ir = out_ready; e_ov = in_valid; e_din = in_data;
                    e_od = in_valid ? mq[0] : 8'h00;
                    e_sh = in_valid && out_ready;
                end
                default: begin
                    if (bub > 0) e_sh = 1;
                    else begin e_ov = 1; e_od = mq[0]; e_sh = out_ready; end
                end
            endcase
        end
        chk("in_ready", 32'(in_ready), 32'(e_ir));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("out_data", 32'(out_data), 32'(e_od));
        chk("sr_shift", 32'(sr_shift), 32'(e_sh));
        chk("sr_din", 32'(sr_din), 32'(e_din));
        chk("fill_count", 32'(fill_count), 32'(mq.size()));
        chk("state", 32'(state), 32'(mst));
        if (sr_shift) shifts++;
        if (out_valid && out_ready) got.push_back(out_data);
        if (state == 2'd3 && !out_valid) bubble_cycles++;
        if (rst) begin
            mq.delete(); mst = 0; bub = 0;
        end else begin
            case (mst)
                0, 1: begin
                    if (in_valid) mq.push_back(in_data);
                    if (flush && mst == 1) begin mst = 3; bub = DEPTH - mq.size(); end
                    else if (mq.size() == DEPTH) mst = 2;
                    else if (mq.size() > 0) mst = 1;
                end
                2: begin
                    if (in_valid && out_ready) begin void'(mq.pop_front()); mq.push_back(in_data); end
                    if (flush) begin mst = 3; bub = 0; end
                end
                default: begin
                    if (bub > 0) bub--;
                    else if (out_ready) begin
                        void'(mq.pop_front());
                        if (mq.size() == 0) mst = 0;
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1; in_data = d;
        step();
        in_valid = 0;
    endtask

    initial begin
        step(); step();
        rst = 0;
        step();
        chk("reset_state", 32'(state), 0);
        chk("reset_fill", 32'(fill_count), 0);

        // Fill to FULL with the output stalled
        shifts = 0;
        push(8'h11); chk("fill1", 32'(fill_count), 1); chk("st_fill", 32'(state), 1);
        push(8'h22); push(8'h33); push(8'h44);
        chk("fill4", 32'(fill_count), 4);
        chk("st_full", 32'(state), 2);
        chk("shifts4", 32'(shifts), 4);
        chk("in_ready_low", 32'(in_ready), 0);

        // Pass-through in FULL with out_ready toggling
        shifts = 0; got.delete();
        in_valid = 1; in_data = 8'h55;
        for (int i = 0; i < 6; i++) begin out_ready = i[0]; step(); end
        in_valid = 0; out_ready = 1;
        step(); step();
        chk("full_shifts", 32'(shifts), 3);
        chk("full_fill", 32'(fill_count), 4);
        chk("full_n", 32'(got.size()), 3);
        if (got.size() == 3) begin
            chk("full_o0", 32'(got[0]), 32'h11);
            chk("full_o1", 32'(got[1]), 32'h22);
            chk("full_o2", 32'(got[2]), 32'h33);
        end
        flush = 1; out_ready = 0; step(); flush = 0;
        out_ready = 1;
        for (int i = 0; i < 4; i++) step();
        chk("full_drained", 32'(state), 0);

        // Flush with two words: two bubbles then both words
        out_ready = 0; got.delete(); bubble_cycles = 0;
        push(8'hA1); push(8'hA2);
        flush = 1; step(); flush = 0;
        chk("drain_enter", 32'(state), 3);
        out_ready = 1;
        for (int i = 0; i < 5; i++) step();
        chk("bubbles", 32'(bubble_cycles), 2);
        chk("drain_n", 32'(got.size()), 2);
        if (got.size() == 2) begin
            chk("drain_o0", 32'(got[0]), 32'hA1);
            chk("drain_o1", 32'(got[1]), 32'hA2);
        end
        chk("drain_empty", 32'(state), 0);
        chk("drain_fill0", 32'(fill_count), 0);

        // Flush coincident with an accepted input
        out_ready = 0; got.delete();
        push(8'h70);
        in_valid = 1; in_data = 8'h77; flush = 1; step();
        in_valid = 0; flush = 0;
        chk("cf_state", 32'(state), 3);
        chk("cf_fill", 32'(fill_count), 2);
        out_ready = 1;
        for (int i = 0; i < 12 && state != 2'd0; i++) step();
        chk("cf_done", 32'(state), 0);
        chk("cf_n", 32'(got.size()), 2);
        if (got.size() == 2) begin
            chk("cf_o0", 32'(got[0]), 32'h70);
            chk("cf_o1", 32'(got[1]), 32'h77);
        end

        // Reset in the middle of a drain
        out_ready = 0;
        push(8'h01); push(8'h02);
        flush = 1; step(); flush = 0;
        out_ready = 1;
        step(); step(); step();
        rst = 1; step(); rst = 0;
        chk("rst_state", 32'(state), 0);
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_sh", 32'(sr_shift), 0);
        push(8'h99);
        chk("rst_refill", 32'(fill_count), 1);
        flush = 1; step(); flush = 0;
        for (int i = 0; i < 12 && state != 2'd0; i++) step();
        chk("rst_refill_done", 32'(state), 0);

        // Flush while EMPTY is ignored
        shifts = 0;
        flush = 1; step(); flush = 0;
        step();
        chk("empty_flush_state", 32'(state), 0);
        chk("empty_flush_shift", 32'(shifts), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shiftreg_ctrl.md
SHIFTREG_CTRL -- requirements
Module: shiftreg_ctrl

Interface
REQ-001 Parameter DEPTH, default 20000: stage count of the controlled shift-register datapath; legal range 2..32767.
REQ-002 Parameter CW, default 15: width of the occupancy and position counters; 2^CW SHALL be greater than DEPTH.
REQ-003 clk  in  1: single clock; all state updates on its rising edge.
REQ-004 rst  in  1: reset, synchronous and active-high.
REQ-005 in_valid  in  1 / in_ready  out  1 / in_data  in  8: upstream write handshake.
REQ-006 out_valid  out  1 / out_ready  in  1 / out_data  out  8: downstream read handshake.
REQ-007 flush  in  1: single-cycle request to drain all stored words.
REQ-008 sr_shift  out  1: drives the datapath shift enable; one pulse moves every stage by one.
REQ-009 sr_din  out  8 / sr_dout  in  8: datapath stage-0 input and last-stage output.
REQ-010 fill_count  out  CW: number of valid words held in the datapath.
REQ-011 state  out  2: EMPTY=0, FILL=1, FULL=2, DRAIN=3.

Function
REQ-012 Internal counters: vcnt (valid words, 0..DEPTH) and lead (stage index of the oldest valid word, 0..DEPTH-1); fill_count SHALL equal vcnt.
REQ-013 Valid words SHALL always occupy contiguous stages lead-vcnt+1..lead.
REQ-014 EMPTY/FILL: in_ready=1, out_valid=0, sr_din=in_data, sr_shift=in_valid.
REQ-015 FULL (vcnt==DEPTH, lead==DEPTH-1): in_ready=out_ready; out_valid=in_valid; out_data=sr_dout; sr_shift=in_valid&&out_ready. The input and output transfers complete together, so vcnt stays unchanged.
REQ-016 Accept in EMPTY/FILL: vcnt+=1 and lead=vcnt (new value minus 1). Transition EMPTY->FILL, or ->FULL when vcnt reaches DEPTH.
REQ-017 DRAIN: in_ready=0, sr_din=0.
  - lead<DEPTH-1: sr_shift=1 every cycle (bubble shift), lead+=1, out_valid=0.
  - lead==DEPTH-1: out_valid=1, out_data=sr_dout, sr_shift=out_ready; on a transfer, vcnt-=1 and lead is unchanged.
REQ-018 DRAIN->EMPTY in the cycle after the transfer that takes vcnt to 0; lead SHALL reset to 0 at that point.
REQ-019 flush in FILL or FULL: next state DRAIN. flush in EMPTY or DRAIN: ignored.
REQ-020 flush coincident with an accepted input: the input is accepted and counted first, then the block enters DRAIN with the updated vcnt/lead.
REQ-021 When not full, sr_shift SHALL never assert without a completed input transfer; in FULL it SHALL assert only when both handshakes complete, so no stored word is ever lost or duplicated.
REQ-022 out_valid SHALL never depend combinationally on out_ready. in_ready SHALL never depend combinationally on in_valid.
REQ-023 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-024 rst=1 at a clock edge: state=EMPTY, vcnt=0, lead=0. While rst is high: sr_shift=0, in_ready=0, out_valid=0, out_data=0, sr_din=0.
REQ-025 rst asserted mid-FILL/FULL/DRAIN SHALL abandon the operation on that edge with no further sr_shift pulses. Datapath contents are then don't-care; the next fill overwrites them.
REQ-026 First accept is possible on the first edge after rst deasserts.

Verification (DEPTH=4)
REQ-027 Push 0x11,0x22,0x33,0x44 with out_ready=0 -> fill_count 1..4; state FILL then FULL; exactly 4 sr_shift pulses; in_ready falls to 0.
REQ-028 FULL, in_valid=1 with 0x55, out_ready toggling 0/1 -> sr_shift only on cycles with out_ready=1; out stream 0x11,0x22,...; fill_count stays 4.
REQ-029 Push 0xA1,0xA2 then flush -> DRAIN; 2 bubble shifts with out_valid=0, then out 0xA1,0xA2 on consecutive out_ready cycles; then EMPTY, fill_count 0.
REQ-030 flush in the same cycle as accepting 0x77 from FILL(vcnt=1) -> DRAIN with fill_count 2; outputs in order are the earlier word then 0x77.
REQ-031 rst pulse mid-DRAIN with out_ready=1 -> next cycle state=EMPTY, out_valid=0, sr_shift=0; a new push then restarts from fill_count 1.
REQ-032 flush while EMPTY -> state stays EMPTY, no sr_shift pulse.
